// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the fetch/loader memory interface: default storage
// placement, the access_size burst-length encoding, the rw encoding and the
// responder FSM state type.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;
    localparam int          DEFAULT_DEPTH     = 1048576;

    localparam logic [1:0] ACC_1W  = 2'b00;
    localparam logic [1:0] ACC_4W  = 2'b01;
    localparam logic [1:0] ACC_8W  = 2'b10;
    localparam logic [1:0] ACC_16W = 2'b11;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    // Number of words moved by a request with the given access_size code.
    function automatic logic [4:0] burst_len(input logic [1:0] acc);
        logic [4:0] len;
        case (acc)
            ACC_1W:  len = 5'd1;
            ACC_4W:  len = 5'd4;
            ACC_8W:  len = 5'd8;
            ACC_16W: len = 5'd16;
            default: len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/burst_mem_responder_if.sv
// ---------------------------------------------------------------------------
// burst_mem_responder_if
// Request/response bundle between a fetch/loader initiator and the memory
// responder.
//   address     : request byte address (low two bits ignored)
//   data_in     : write data for the current beat
//   access_size : burst length code (00=1, 01=4, 10=8, 11=16 words)
//   rw          : 0 = write, 1 = read
//   enable      : request strobe, only looked at while the responder is idle
//   busy        : burst beats remain after the current edge
//   data_out    : read data
//   data_valid  : data_out carries a read beat this cycle
//   addr_err    : the beat just processed was out of range
// ---------------------------------------------------------------------------
interface burst_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            access_size;
    logic                  rw;
    logic                  enable;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  addr_err;

    modport master (
        output address, data_in, access_size, rw, enable,
        input  busy, data_out, data_valid, addr_err
    );

    modport slave (
        input  address, data_in, access_size, rw, enable,
        output busy, data_out, data_valid, addr_err
    );
endinterface

// File: rtl/mem_byte_array.sv
// ---------------------------------------------------------------------------
// mem_byte_array
// Byte-addressed storage with one word write port and one registered word
// read port. Lanes are big-endian: the most significant byte of a word lives
// at the lowest byte offset. Contents have no reset.
//   clock   : rising-edge clock
//   wr_en   : write the word wr_data at byte offset wr_off
//   wr_off  : word-aligned byte offset of the write
//   wr_data : write word
//   rd_en   : capture the word at rd_off into rd_data
//   rd_off  : word-aligned byte offset of the read
//   rd_data : registered read word (holds when rd_en is low)
// ---------------------------------------------------------------------------
module mem_byte_array #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1048576,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_off,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_off,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [7:0] mem [DEPTH];

    // Word write, most significant byte to the lowest offset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                mem[wr_off + IDX_W'(i)] <= wr_data[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    // Registered word read, same lane order as the write port.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            for (int i = 0; i < BYTES; i++) begin
                rd_data[DATA_WIDTH-1-8*i -: 8] <= mem[rd_off + IDX_W'(i)];
            end
        end
    end

endmodule

// File: rtl/burst_mem_responder.sv
// ---------------------------------------------------------------------------
// burst_mem_responder
// Memory-side responder for the fetch/loader interface. A request seen while
// idle is served immediately as beat 0; the remaining beats of a burst follow
// on consecutive edges at increasing word addresses. Each beat is range
// checked against [BASE_ADDR, BASE_ADDR+DEPTH): out-of-range writes are
// dropped, out-of-range reads return zero, and both pulse addr_err.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset (storage is not cleared)
//   bus     : slave side of burst_mem_responder_if
// ---------------------------------------------------------------------------
module burst_mem_responder
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    burst_mem_responder_if.slave   bus
);
    localparam int                    IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~ADDR_WIDTH'(3);

    burst_state_e          state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  rw_r;
    logic [4:0]            remain_r;
    logic                  busy_r;
    logic                  valid_r;
    logic                  err_r;
    logic                  zero_r;

    logic                  beat_s;
    logic                  beat_rw_s;
    logic [ADDR_WIDTH-1:0] beat_addr_s;
    logic [ADDR_WIDTH-1:0] offset_s;
    logic                  in_range_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic [4:0]            len_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Select the beat for this edge: the new request when idle, the latched
    // burst position otherwise; then range check it.
    always_comb begin
        beat_s      = 1'b0;
        beat_rw_s   = rw_r;
        beat_addr_s = addr_r;
        len_s       = burst_len(bus.access_size);
        case (state_r)
            ST_IDLE: begin
                beat_s      = bus.enable;
                beat_rw_s   = bus.rw;
                beat_addr_s = bus.address & ALIGN_MSK;
            end
            ST_BURST: begin
                beat_s = 1'b1;
            end
            default: begin
                beat_s = 1'b0;
            end
        endcase
        // Wrapping subtraction: addresses below BASE_ADDR become huge offsets
        // and fail the same single compare as addresses past the top.
        offset_s   = beat_addr_s - BASE_ADDR;
        in_range_s = (offset_s < DEPTH_A);
        wr_en_s    = beat_s && (beat_rw_s == RW_WRITE) && in_range_s;
        rd_en_s    = beat_s && (beat_rw_s == RW_READ) && in_range_s;
    end

    // Beat sequencing FSM with registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            rw_r     <= RW_READ;
            remain_r <= 5'd0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            zero_r   <= 1'b1;
        end else begin
            if (beat_s) begin
                valid_r <= (beat_rw_s == RW_READ);
                err_r   <= !in_range_s;
                addr_r  <= beat_addr_s + WORD_STEP;
                // Only reads change what data_out shows; writes leave it alone.
                if (beat_rw_s == RW_READ) begin
                    zero_r <= !in_range_s;
                end
            end else begin
                valid_r <= 1'b0;
                err_r   <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.enable) begin
                        rw_r     <= bus.rw;
                        remain_r <= len_s - 5'd1;
                        if (len_s > 5'd1) begin
                            state_r <= ST_BURST;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    remain_r <= remain_r - 5'd1;
                    if (remain_r == 5'd1) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    mem_byte_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en_s),
        .wr_off  (offset_s[IDX_W-1:0]),
        .wr_data (bus.data_in),
        .rd_en   (rd_en_s),
        .rd_off  (offset_s[IDX_W-1:0]),
        .rd_data (rd_word_s)
    );

    // The storage read register has no reset, so a registered zero flag masks
    // it after reset and after out-of-range reads.
    assign bus.data_out   = zero_r ? '0 : rd_word_s;
    assign bus.busy       = busy_r;
    assign bus.data_valid = valid_r;
    assign bus.addr_err   = err_r;

endmodule

// File: tb/tb_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_burst_mem_responder
// Directed stimulus with a scoreboard: read expectations are queued when a
// burst is issued and a monitor compares them against each valid beat.
// ---------------------------------------------------------------------------
module tb_burst_mem_responder;
    import mem_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    burst_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    burst_mem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (1048576),
        .BASE_ADDR  (32'h8002_0000)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks       = 0;
    int          errors       = 0;
    int          busy_cnt     = 0;
    int          err_only_cnt = 0;
    logic [31:0] wbuf [16];
    int          b0;
    int          e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Drive one request and all of its beats; word k is presented during the
    // cycle before beat edge k. inject_at pulses enable mid-burst.
    task automatic run_burst(input logic rw_i, input logic [31:0] a,
                             input logic [1:0] sz, input int inject_at);
        int n;
        n = int'(burst_len(sz));
        @(posedge clock); #1;
        bus.enable      = 1'b1;
        bus.address     = a;
        bus.rw          = rw_i;
        bus.access_size = sz;
        bus.data_in     = wbuf[0];
        for (int k = 1; k < n; k++) begin
            @(posedge clock); #1;
            bus.enable  = 1'b0;
            bus.address = 32'h0;
            bus.data_in = wbuf[k];
            if (k == inject_at) begin
                bus.enable  = 1'b1;
                bus.address = 32'h8002_0040;
            end
        end
        @(posedge clock); #1;
        bus.enable = 1'b0;
    endtask

    task automatic settle();
        @(negedge clock); #1;
    endtask

    // Monitor: count busy cycles, score every valid beat, count write errors.
    always @(negedge clock) begin
        if (bus.busy) busy_cnt++;
        if (bus.data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got %h expected no beat", bus.data_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", bus.data_out, mon_e.data);
                chk("rd_err", {31'b0, bus.addr_err}, {31'b0, mon_e.err});
            end
        end else if (bus.addr_err) begin
            err_only_cnt++;
        end
    end

    initial begin
        bus.enable      = 1'b0;
        bus.address     = 32'h0;
        bus.data_in     = 32'h0;
        bus.rw          = RW_READ;
        bus.access_size = ACC_1W;
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_valid", {31'b0, bus.data_valid}, 32'h0);
        chk("rst_data", bus.data_out, 32'h0);
        chk("rst_err", {31'b0, bus.addr_err}, 32'h0);
        reset_n = 1'b1;

        // Single word write then read back
        wbuf[0] = 32'hDEAD_BEEF;
        b0 = busy_cnt;
        run_burst(RW_WRITE, 32'h8002_0000, ACC_1W, -1);
        push_exp(32'hDEAD_BEEF, 1'b0);
        run_burst(RW_READ, 32'h8002_0000, ACC_1W, -1);
        settle();
        chk("single_busy_cycles", 32'(busy_cnt - b0), 32'd0);

        // 4-word write and read
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
        wbuf[2] = 32'h3333_3333; wbuf[3] = 32'h4444_4444;
        b0 = busy_cnt;
        run_burst(RW_WRITE, 32'h8002_0010, ACC_4W, -1);
        settle();
        chk("wr4_busy_cycles", 32'(busy_cnt - b0), 32'd3);
        push_exp(32'h1111_1111, 1'b0); push_exp(32'h2222_2222, 1'b0);
        push_exp(32'h3333_3333, 1'b0); push_exp(32'h4444_4444, 1'b0);
        b0 = busy_cnt;
        run_burst(RW_READ, 32'h8002_0010, ACC_4W, -1);
        settle();
        chk("rd4_busy_cycles", 32'(busy_cnt - b0), 32'd3);

        // 16-word load then read with a stray enable mid-burst
        for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
        run_burst(RW_WRITE, 32'h8002_0000, ACC_16W, -1);
        for (int i = 0; i < 16; i++) push_exp(32'(i), 1'b0);
        b0 = busy_cnt;
        run_burst(RW_READ, 32'h8002_0000, ACC_16W, 5);
        settle();
        chk("rd16_busy_cycles", 32'(busy_cnt - b0), 32'd15);
        settle();
        chk("rd16_no_extra", 32'(exp_q.size()), 32'd0);

        // Out-of-range singles: below base and at base+depth
        push_exp(32'h0, 1'b1);
        run_burst(RW_READ, 32'h8001_FFFC, ACC_1W, -1);
        push_exp(32'h0, 1'b1);
        run_burst(RW_READ, 32'h8012_0000, ACC_1W, -1);

        // 8-word burst running off the top of storage
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
        settle();
        e0 = err_only_cnt;
        run_burst(RW_WRITE, 32'h8011_FFF8, ACC_8W, -1);
        settle();
        chk("oor_wr_err_pulses", 32'(err_only_cnt - e0), 32'd6);
        push_exp(32'hA000_0000, 1'b0);
        push_exp(32'hA000_0001, 1'b0);
        for (int i = 0; i < 6; i++) push_exp(32'h0, 1'b1);
        run_burst(RW_READ, 32'h8011_FFF8, ACC_8W, -1);
        settle();

        // Byte order in storage
        wbuf[0] = 32'h0A0B_0C0D;
        run_burst(RW_WRITE, 32'h8002_0020, ACC_1W, -1);
        settle();
        chk("byte_0x20", {24'h0, u_dut.u_mem.mem[32'h20]}, 32'h0000_000A);
        chk("byte_0x23", {24'h0, u_dut.u_mem.mem[32'h23]}, 32'h0000_000D);

        // Reset in the middle of an 8-word write
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hB000_0000 + 32'(i);
        run_burst(RW_WRITE, 32'h8002_0080, ACC_8W, -1);
        for (int i = 0; i < 8; i++) push_exp(32'hB000_0000 + 32'(i), 1'b0);
        run_burst(RW_READ, 32'h8002_0080, ACC_8W, -1);
        settle();
        @(posedge clock); #1;
        bus.enable      = 1'b1;
        bus.rw          = RW_WRITE;
        bus.address     = 32'h8002_0080;
        bus.access_size = ACC_8W;
        bus.data_in     = 32'hC000_0000;
        @(posedge clock); #1;
        bus.enable  = 1'b0;
        bus.data_in = 32'hC000_0001;
        @(posedge clock); #1;
        bus.data_in = 32'hC000_0002;
        chk("pre_rst_busy", {31'b0, bus.busy}, 32'h1);
        chk("pre_rst_data", bus.data_out, 32'hB000_0007);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("mid_rst_valid", {31'b0, bus.data_valid}, 32'h0);
        chk("mid_rst_data", bus.data_out, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        push_exp(32'hC000_0000, 1'b0);
        push_exp(32'hC000_0001, 1'b0);
        for (int i = 2; i < 8; i++) push_exp(32'hB000_0000 + 32'(i), 1'b0);
        run_burst(RW_READ, 32'h8002_0080, ACC_8W, -1);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        settle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
